// File: rtl/noise_pkg.sv
// Shared definitions for the noise generator family: channel-index width,
// load FSM state type and the XNOR LFSR step used by other sound blocks.
package noise_pkg;

  localparam int NOISE_CH_IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } load_state_e;

  // One XNOR-feedback step on a right-justified state of up to 32 bits.
  // taps = {tap_b[4:0], tap_a[4:0]}; the caller keeps the low WIDTH bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [9:0]  taps);
    logic fb;
    fb = ~(state[taps[4:0]] ^ state[taps[9:5]]);
    return {state[30:0], fb};
  endfunction

endpackage

// File: rtl/noise_lfsr_channel.sv
// One noise channel: XNOR LFSR, tick divider and optional all-ones
// lock-up recovery (enabled by NOISE_LFSR_LOCKUP_RECOVER_EN).
module noise_lfsr_channel
  import noise_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAP_A = 0,
  parameter int TAP_B = 14,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en,
  input  logic [DIV_W-1:0] div,
  input  logic             wr,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  localparam logic [9:0] TAPS = {5'(TAP_B), 5'(TAP_A)};

  logic [WIDTH-1:0] s;
  logic [DIV_W-1:0] cnt;
  logic             recover;

`ifdef NOISE_LFSR_LOCKUP_RECOVER_EN
  assign recover = &s;
`else
  assign recover = 1'b0;
`endif

  // LFSR and divider: a write beats recovery, recovery beats a due shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s   <= '0;
      cnt <= '0;
    end else if (wr) begin
      s   <= seed;
      cnt <= div;
    end else if (recover) begin
      s   <= '0;
      cnt <= div;
    end else if (tick_en) begin
      if (cnt == '0) begin
        s   <= WIDTH'(lfsr_next(32'(s), TAPS));
        cnt <= div;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Lock-up pulse is registered so it lines up with the cleared state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lockup <= 1'b0;
    else        lockup <= recover & ~wr;
  end

  assign state = s;

endmodule

// File: rtl/noise_lfsr_bank.sv
// Multi-channel XNOR LFSR noise generator with run-time seed loading.
// Optional lock-up recovery: define NOISE_LFSR_LOCKUP_RECOVER_EN.
module noise_lfsr_bank
  import noise_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int TAP_A    = 0,
  parameter int TAP_B    = 14,
  parameter int DIV_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick_en,
  input  logic [CHANNELS*DIV_W-1:0] div,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [2:0]                load_ch,
  input  logic [WIDTH-1:0]          load_seed,
  output logic [CHANNELS-1:0]       noise,
  output logic [CHANNELS*WIDTH-1:0] lfsr_q,
  output logic [CHANNELS-1:0]       lockup
);

  load_state_e                state_q, state_d;
  logic [NOISE_CH_IDX_W-1:0]  ch_q;
  logic [WIDTH-1:0]           seed_q;

  // Load FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Load FSM next state: accept in IDLE, spend exactly one cycle in WRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_valid) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load_ready = (state_q == IDLE);

  // Capture target and seed on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      seed_q <= '0;
    end else if (state_q == IDLE && load_valid) begin
      ch_q   <= load_ch;
      seed_q <= load_seed;
    end
  end

  // Out-of-range channel indices match no channel, so the write is dropped.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic             wr;
    logic [WIDTH-1:0] st;

    assign wr = (state_q == WRITE) && (ch_q == NOISE_CH_IDX_W'(c));

    noise_lfsr_channel #(
      .WIDTH (WIDTH),
      .TAP_A (TAP_A),
      .TAP_B (TAP_B),
      .DIV_W (DIV_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_en (tick_en),
      .div     (div[c*DIV_W +: DIV_W]),
      .wr      (wr),
      .seed    (seed_q),
      .state   (st),
      .lockup  (lockup[c])
    );

    assign lfsr_q[c*WIDTH +: WIDTH] = st;
    assign noise[c]                 = st[WIDTH-1];
  end

endmodule

// File: tb/tb_noise_lfsr_bank.sv
// Self-checking bench for noise_lfsr_bank with a behavioural reference model.
module tb_noise_lfsr_bank;

  localparam int WIDTH = 16;
  localparam int CH    = 2;
  localparam int DIV_W = 8;
  localparam int TAP_A = 0;
  localparam int TAP_B = 14;
`ifdef NOISE_LFSR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   tick_en = 1'b0;
  logic [CH*DIV_W-1:0]    div = '0;
  logic                   load_valid = 1'b0;
  logic                   load_ready;
  logic [2:0]             load_ch = '0;
  logic [WIDTH-1:0]       load_seed = '0;
  logic [CH-1:0]          noise;
  logic [CH*WIDTH-1:0]    lfsr_q;
  logic [CH-1:0]          lockup;

  noise_lfsr_bank #(
    .WIDTH(WIDTH), .CHANNELS(CH), .TAP_A(TAP_A), .TAP_B(TAP_B), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .div(div),
    .load_valid(load_valid), .load_ready(load_ready), .load_ch(load_ch),
    .load_seed(load_seed), .noise(noise), .lfsr_q(lfsr_q), .lockup(lockup)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: per-channel state, ticks remaining before next shift,
  // and a pending load (channel, seed) waiting for its write edge.
  logic [WIDTH-1:0] m_s    [CH];
  int               m_wait [CH];
  bit               m_lock [CH];
  bit               m_pend;
  int               m_pch;
  logic [WIDTH-1:0] m_pseed;

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] v);
    bit fb;
    fb = !(v[TAP_A] ^ v[TAP_B]);
    return {v[WIDTH-2:0], fb};
  endfunction

  function automatic int div_of(input int c);
    logic [CH*DIV_W-1:0] d;
    d = div;
    return int'(d[c*DIV_W +: DIV_W]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_s[c] = '0; m_wait[c] = 0; m_lock[c] = 1'b0;
    end
    m_pend = 1'b0; m_pch = 0; m_pseed = '0;
  endtask

  task automatic model_edge(input bit tk, input bit v, input int ch,
                            input logic [WIDTH-1:0] sd);
    for (int c = 0; c < CH; c++) begin
      m_lock[c] = 1'b0;
      if (m_pend && m_pch == c) begin
        m_s[c] = m_pseed; m_wait[c] = div_of(c);
      end else if (RECOVER && m_s[c] == {WIDTH{1'b1}}) begin
        m_s[c] = '0; m_wait[c] = div_of(c); m_lock[c] = 1'b1;
      end else if (tk) begin
        if (m_wait[c] == 0) begin
          m_s[c] = ref_shift(m_s[c]); m_wait[c] = div_of(c);
        end else begin
          m_wait[c] = m_wait[c] - 1;
        end
      end
    end
    if (m_pend) m_pend = 1'b0;
    else if (v) begin
      m_pend = 1'b1; m_pch = ch; m_pseed = sd;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("%s lfsr_q[%0d]", tag, c), 32'(lfsr_q[c*WIDTH +: WIDTH]), 32'(m_s[c]));
      check($sformatf("%s noise[%0d]", tag, c), 32'(noise[c]), 32'(m_s[c][WIDTH-1]));
      check($sformatf("%s lockup[%0d]", tag, c), 32'(lockup[c]), 32'(m_lock[c]));
    end
    check({tag, " load_ready"}, 32'(load_ready), 32'(!m_pend));
  endtask

  task automatic step(input string tag, input bit tk, input bit v,
                      input int ch, input logic [WIDTH-1:0] sd);
    tick_en = tk; load_valid = v; load_ch = 3'(ch); load_seed = sd;
    @(posedge clk); #1;
    model_edge(tk, v, ch, sd);
    tick_en = 1'b0; load_valid = 1'b0;
    check_all(tag);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    model_reset();
    #2;
    check_all("por");
    apply_reset();
    step("idle", 1'b0, 1'b0, 0, '0);

    // Default dividers, 16 ticks
    for (int t = 1; t <= 16; t++) begin
      step($sformatf("tick%0d", t), 1'b1, 1'b0, 0, '0);
      if (t == 1) check("seq t1", 32'(lfsr_q[15:0]), 32'h0001);
      if (t == 2) check("seq t2", 32'(lfsr_q[15:0]), 32'h0002);
      if (t == 3) check("seq t3", 32'(lfsr_q[15:0]), 32'h0005);
      if (t == 15) check("noise t15", 32'(noise[0]), 32'h0);
      if (t == 16) check("noise t16", 32'(noise[0]), 32'h1);
    end

    // Divider 3 on channel 0, 0 on channel 1
    apply_reset();
    div = {8'd0, 8'd3};
    for (int t = 1; t <= 8; t++) step($sformatf("div t%0d", t), 1'b1, 1'b0, 0, '0);

    // Load channel 1 with valid held across the write edge
    step("ld1 acc", 1'b0, 1'b1, 1, 16'h1234);
    check("ld1 ready low", 32'(load_ready), 32'h0);
    step("ld1 wr", 1'b0, 1'b1, 1, 16'h1234);
    check("ld1 seed", 32'(lfsr_q[31:16]), 32'h1234);
    check("ld1 ready high", 32'(load_ready), 32'h1);
    step("ld1 idle", 1'b0, 1'b0, 0, '0);

    // Load colliding with a due shift on channel 0
    div = '0;
    for (int t = 0; t < 4; t++) step("flush", 1'b1, 1'b0, 0, '0);
    step("col acc", 1'b0, 1'b1, 0, 16'h00FF);
    step("col wr", 1'b1, 1'b0, 0, '0);
    check("col seed", 32'(lfsr_q[15:0]), 32'h00FF);
    step("col next", 1'b1, 1'b0, 0, '0);

    // All-ones seed on channel 0
    step("lk acc", 1'b0, 1'b1, 0, 16'hFFFF);
    step("lk wr", 1'b0, 1'b0, 0, '0);
    step("lk next", 1'b0, 1'b0, 0, '0);
    check("lk state", 32'(lfsr_q[15:0]), RECOVER ? 32'h0000 : 32'hFFFF);
    check("lk pulse", 32'(lockup[0]), 32'(RECOVER));
    for (int t = 0; t < 10; t++) step("lk tick", 1'b1, 1'b0, 0, '0);

    // Out-of-range channel
    step("oor acc", 1'b0, 1'b1, 5, 16'hABCD);
    step("oor wr", 1'b0, 1'b0, 0, '0);
    step("oor idle", 1'b0, 1'b0, 0, '0);

    // Randomized traffic, including invalid channels and divider changes
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 3)), WIDTH'($urandom));
      if ($urandom_range(0, 15) == 0) div = (CH*DIV_W)'($urandom) & {CH{8'h07}};
    end

    // Reset asserted during the WRITE cycle
    step("rw acc", 1'b0, 1'b1, 1, 16'h5A5A);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rw in reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("rw after", 1'b0, 1'b0, 0, '0);
    step("rw tick", 1'b1, 1'b0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
